// File: rtl/mem_unit_seq.sv
// -----------------------------------------------------------------------------
// mem_unit_seq
//   Byte-addressed RAM sitting behind a MAR/MDR pair on the CPU bus. The
//   control unit starts a byte or word transfer with req_read / req_write and
//   stalls while busy is high. A transfer moves one byte per clock, little-
//   endian, starting at MAR. The address wraps modulo DEPTH. done pulses for
//   one cycle once the last byte has been moved.
//
//   Sequence: IDLE -> XFER (n clocks) -> DONE (1 clock) -> IDLE.
//   n = 1 for a byte transfer and DATA_W/8 for a word transfer.
//
// Parameters
//   DATA_W     MDR/bus width in bits (multiple of 8, 8..64)
//   ADDR_W     MAR width in bits
//   DEPTH      RAM size in bytes (power of two, <= 2**ADDR_W)
//   INIT_FILE  RAM image name (not loaded by this model)
//   PROT_LIMIT bytes [0,PROT_LIMIT) are write-protected when MEM_PROTECT_EN
//              is defined
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-high (RAM contents kept)
//   data_in      in   bus input (MAR / MDR load source)
//   out          out  MDR contents
//   mar_out      out  current MAR
//   mar_load     in   MAR <= data_in (IDLE only)
//   mdr_load_bus in   MDR <= data_in (IDLE only)
//   req_read     in   start read of RAM[MAR..] into MDR (wins over write)
//   req_write    in   start write of MDR into RAM[MAR..]
//   size         in   0 = byte, 1 = word; sampled with the request
//   busy         out  high while bytes are being transferred
//   done         out  one-cycle pulse after the last byte
//   fault        out  sticky write-protection fault
//
// Build option
//   MEM_PROTECT_EN  When defined, any write byte whose address is below
//                   PROT_LIMIT is dropped and fault is set. The transfer
//                   still runs its full length. fault clears on the next
//                   accepted request or on reset. When the macro is not
//                   defined, fault is tied low.
// -----------------------------------------------------------------------------
module mem_unit_seq #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH      = 256,
  parameter string       INIT_FILE  = "program.hex",
  parameter int unsigned PROT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] out,
  output logic [ADDR_W-1:0] mar_out,
  input  logic              mar_load,
  input  logic              mdr_load_bus,
  input  logic              req_read,
  input  logic              req_write,
  input  logic              size,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t             state_reg, state_next;
  logic               accept;
  logic               busy_reg, done_reg;

  logic [ADDR_W-1:0]  mar_reg;
  logic [ADDR_W-1:0]  mar_src;
  logic [7:0]         mdr_bytes_reg [NBYTES];
  logic [DATA_W-1:0]  mdr_word;

  // Transfer context, latched when a request is accepted. This lets MAR and
  // MDR be reloaded on that same edge without disturbing the transfer.
  logic [IDX_W-1:0]   base_reg;
  logic [7:0]         wdata_bytes_reg [NBYTES];
  logic [CNT_W-1:0]   idx_reg;
  logic [CNT_W-1:0]   last_reg;
  logic               op_write_reg;

  logic [IDX_W-1:0]   cur_addr;
  logic [IDX_W-1:0]   rd_addr;
  logic [7:0]         rd_data_reg;
  logic [7:0]         wr_byte;
  logic               ram_we;
  logic               prot_hit;
  logic               unused_init;

  logic [7:0]         ram [DEPTH];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == ST_XFER);
      done_reg  <= (state_next == ST_DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and accept strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (req_read || req_write) begin
          accept     = 1'b1;
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (idx_reg == last_reg) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Requests are not taken here. They are only sampled again in IDLE.
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // MAR source: zero-extend the bus when MAR is wider than the bus
  // ---------------------------------------------------------------------------
  if (ADDR_W <= DATA_W) begin : g_mar_narrow
    assign mar_src = data_in[ADDR_W-1:0];
  end else begin : g_mar_wide
    assign mar_src = {{(ADDR_W-DATA_W){1'b0}}, data_in};
  end

  // ---------------------------------------------------------------------------
  // MAR and transfer context
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar_reg      <= '0;
      base_reg     <= '0;
      idx_reg      <= '0;
      last_reg     <= '0;
      op_write_reg <= 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
        wdata_bytes_reg[i] <= '0;
      end
    end else begin
      // A request in the same cycle still sees the old MAR through base_reg.
      if ((state_reg == ST_IDLE) && mar_load) begin
        mar_reg <= mar_src;
      end
      if (accept) begin
        base_reg     <= mar_reg[IDX_W-1:0];
        idx_reg      <= '0;
        last_reg     <= size ? CNT_W'(NBYTES - 1) : '0;
        op_write_reg <= !req_read;
        for (int i = 0; i < NBYTES; i++) begin
          wdata_bytes_reg[i] <= mdr_bytes_reg[i];
        end
      end else if (state_reg == ST_XFER) begin
        idx_reg <= idx_reg + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // MDR byte lanes
  // A read accept clears every lane so that a byte read comes out zero-extended.
  // Each XFER cycle of a read then fills lane idx from the RAM output register.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mdr_bytes_reg[gi] <= '0;
      end else if (accept && req_read) begin
        mdr_bytes_reg[gi] <= '0;
      end else if ((state_reg == ST_IDLE) && mdr_load_bus) begin
        mdr_bytes_reg[gi] <= data_in[8*gi +: 8];
      end else if ((state_reg == ST_XFER) && !op_write_reg &&
                   (idx_reg == CNT_W'(gi))) begin
        mdr_bytes_reg[gi] <= rd_data_reg;
      end
    end
  end

  always_comb begin
    mdr_word = '0;
    for (int i = 0; i < NBYTES; i++) begin
      mdr_word[8*i +: 8] = mdr_bytes_reg[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Addressing
  // The RAM read port is registered. To keep the read latency at one byte per
  // clock, the read address runs one byte ahead: MAR while idle (which covers
  // the accept edge), then base+idx+1 during XFER.
  // ---------------------------------------------------------------------------
  assign cur_addr = base_reg + IDX_W'(idx_reg);

  always_comb begin
    rd_addr = mar_reg[IDX_W-1:0];
    if (state_reg == ST_XFER) begin
      rd_addr = cur_addr + IDX_W'(1);
    end
  end

  assign wr_byte = wdata_bytes_reg[idx_reg];
  assign ram_we  = (state_reg == ST_XFER) && op_write_reg && !prot_hit;

  // ---------------------------------------------------------------------------
  // Write protection
  // ---------------------------------------------------------------------------
`ifdef MEM_PROTECT_EN
  logic fault_reg;

  assign prot_hit = (state_reg == ST_XFER) && op_write_reg &&
                    (32'(cur_addr) < 32'(PROT_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_reg <= 1'b0;
    end else if (accept) begin
      fault_reg <= 1'b0;
    end else if (prot_hit) begin
      fault_reg <= 1'b1;
    end
  end

  assign fault = fault_reg;
`else
  logic unused_prot;

  assign prot_hit    = 1'b0;
  assign fault       = 1'b0;
  assign unused_prot = (PROT_LIMIT == 0);
`endif

  // ---------------------------------------------------------------------------
  // Byte RAM: single write port and a registered read port.
  // It has no reset, so its contents survive rst.
  // ---------------------------------------------------------------------------
  assign unused_init = (INIT_FILE == "");

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[cur_addr] <= wr_byte;
    end
    rd_data_reg <= ram[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out     = mdr_word;
  assign mar_out = mar_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_mem_unit_seq.sv
`timescale 1ns/1ps
// Bench for mem_unit_seq.
// A transaction-level model (a byte array plus a timeline of accept edges)
// predicts MAR, MDR, busy, done and fault. A compare process checks these on
// every falling edge. Directed scenarios pin the model with literal values,
// and a random phase follows.
module tb_mem_unit_seq;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 256;
  localparam int NB    = DW / 8;
  localparam int PL    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] out;
  logic [AW-1:0] mar_out;
  logic          mar_load = 1'b0;
  logic          mdr_load_bus = 1'b0;
  logic          req_read = 1'b0;
  logic          req_write = 1'b0;
  logic          size = 1'b0;
  logic          busy, done, fault;

  always #5 clk = ~clk;

  mem_unit_seq #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .INIT_FILE(""), .PROT_LIMIT(PL)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .out(out), .mar_out(mar_out),
    .mar_load(mar_load), .mdr_load_bus(mdr_load_bus), .req_read(req_read),
    .req_write(req_write), .size(size), .busy(busy), .done(done), .fault(fault)
  );

  int tests = 0;
  int fails = 0;

  // Model state. acc_a is the edge at which the last request was accepted and
  // acc_n is its byte count. busy holds after edges [acc_a, acc_a+acc_n-1],
  // done follows edge acc_a+acc_n, and the unit is idle from edge acc_a+acc_n+1.
  int            edge_cnt = 0;
  int            acc_a = -100;
  int            acc_n = 1;
  bit            checking = 1'b0;
  logic [AW-1:0] m_mar = '0;
  logic [DW-1:0] m_mdr = '0;
  logic          m_fault = 1'b0;
  logic [7:0]    mram [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a);
    return b ^ 8'h5A;
  endfunction

  always @(negedge clk) begin : cmp
    bit in_busy;
    if (checking) begin
      in_busy = (edge_cnt >= acc_a) && (edge_cnt < acc_a + acc_n);
      chk("busy", busy, in_busy);
      chk("done", done, edge_cnt == acc_a + acc_n);
      chk("mar", mar_out, m_mar);
      if (!in_busy) begin
        chk("mdr", out, m_mdr);
        chk("fault", fault, m_fault);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Drive one cycle of inputs, predict the result of the next edge, then move past that edge.
  task automatic step(input bit rd, input bit wr, input bit sz, input bit ml,
                      input bit mdl, input logic [DW-1:0] din);
    bit            idle, acc, prot;
    int            n, base, a;
    logic [AW-1:0] p_mar;
    logic [DW-1:0] p_mdr, val;
    logic          p_fault;
    idle = (edge_cnt >= acc_a + acc_n + 1) && !rst;
    req_read = rd; req_write = wr; size = sz;
    mar_load = ml; mdr_load_bus = mdl; data_in = din;
    p_mar = m_mar; p_mdr = m_mdr; p_fault = m_fault;
    acc = 1'b0; n = 1; val = '0;
    if (idle) begin
      if (rd || wr) begin
        acc     = 1'b1;
        n       = sz ? NB : 1;
        base    = int'(m_mar) % DEPTH;
        p_fault = 1'b0;
        if (rd) begin
          for (int i = 0; i < n; i++) val[8*i +: 8] = mram[(base + i) % DEPTH];
          p_mdr = val;
        end else begin
          for (int i = 0; i < n; i++) begin
            a    = (base + i) % DEPTH;
            prot = 1'b0;
`ifdef MEM_PROTECT_EN
            prot = (a < PL);
`endif
            if (prot) p_fault = 1'b1;
            else      mram[a] = m_mdr[8*i +: 8];
          end
          if (mdl) p_mdr = din;
        end
        $display("[TB] txn %s %s addr=0x%02h data=0x%04h", rd ? "RD" : "WR",
                 sz ? "word" : "byte", base, rd ? val : m_mdr);
      end else if (mdl) begin
        p_mdr = din;
      end
      if (ml) p_mar = din;
    end
    tick();
    if (acc) begin
      acc_a = edge_cnt;
      acc_n = n;
    end
    m_mar = p_mar; m_mdr = p_mdr; m_fault = p_fault;
  endtask

  task automatic idle_wait();
    while (edge_cnt < acc_a + acc_n + 1) step(0, 0, 0, 0, 0, '0);
  endtask

  task automatic set_mar(input logic [DW-1:0] v);
    step(0, 0, 0, 1, 0, v);
  endtask

  task automatic set_mdr(input logic [DW-1:0] v);
    step(0, 0, 0, 0, 1, v);
  endtask

  task automatic xfer(input bit rd, input bit sz);
    step(rd, !rd, sz, 0, 0, '0);
    idle_wait();
  endtask

  initial begin
    logic [7:0] save31;
    for (int i = 0; i < DEPTH; i++) mram[i] = 8'h00;

    // Reset state is checked while rst is still asserted.
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mar", mar_out, 0);
    chk("rst_mdr", out, 0);
    chk("rst_fault", fault, 0);
    tick();
    tick();
    rst = 1'b0;
    checking = 1'b1;

    // Fill the RAM with a known pattern using word writes.
    for (int a = 0; a < DEPTH; a += 2) begin
      set_mar(16'(a));
      set_mdr({pat(a + 1), pat(a)});
      xfer(0, 1);
    end

    // Word write 0xBEEF at 0x10, then a word read with the timing checked literally.
    set_mar(16'h0010);
    set_mdr(16'hBEEF);
    xfer(0, 1);
    set_mdr(16'h0000);
    step(1, 0, 1, 0, 0, '0);
    chk("t1_busy_c1", busy, 1);
    chk("t1_done_c1", done, 0);
    step(0, 0, 0, 0, 0, '0);
    chk("t1_busy_c2", busy, 1);
    step(0, 0, 0, 0, 0, '0);
    chk("t1_done_c3", done, 1);
    chk("t1_busy_c3", busy, 0);
    chk("t1_mdr", out, 16'hBEEF);
    idle_wait();
    set_mar(16'h0011);
    xfer(1, 0);
    chk("t1_ram11", out, 16'h00BE);

    // Word write at 0xFF wraps its second byte to address 0x00.
    set_mar(16'h00FF);
    set_mdr(16'h1234);
    xfer(0, 1);
    set_mdr(16'h0000);
    xfer(1, 1);
    chk("t2_wrap_word", out, 16'h1234);
    set_mar(16'h0000);
    xfer(1, 0);
    chk("t2_ram00", out, 16'h0012);

    // Byte read zero-extends, and done comes 2 clocks after the request.
    set_mar(16'h0020);
    set_mdr(16'h00A5);
    xfer(0, 0);
    set_mdr(16'hFFFF);
    step(1, 0, 0, 0, 0, '0);
    chk("t3_busy", busy, 1);
    step(0, 0, 0, 0, 0, '0);
    chk("t3_done", done, 1);
    chk("t3_mdr", out, 16'h00A5);
    idle_wait();

    // Inputs pulsed during XFER and during DONE are ignored.
    set_mar(16'h0050);
    set_mdr(16'h1111);
    step(0, 1, 1, 0, 0, '0);
    step(1, 0, 0, 1, 0, 16'h0040);
    chk("t4_mar_held", mar_out, 16'h0050);
    step(0, 0, 0, 0, 1, 16'h5555);
    chk("t4_done", done, 1);
    step(1, 1, 1, 1, 1, 16'h5555);
    chk("t4_mar", mar_out, 16'h0050);
    chk("t4_mdr", out, 16'h1111);
    set_mdr(16'h0000);
    xfer(1, 1);
    chk("t4_next_req", out, 16'h1111);

    // Reset after the first XFER edge of a word write.
    set_mar(16'h0030);
    set_mdr(16'hCAFE);
    save31 = mram[8'h31];
    step(0, 1, 1, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    rst = 1'b1;
    acc_a = -100; acc_n = 1;
    m_mar = '0; m_mdr = '0; m_fault = 1'b0;
    mram[8'h31] = save31;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_mar", mar_out, 0);
    chk("t5_mdr", out, 0);
    tick();
    rst = 1'b0;
    set_mar(16'h0030);
    xfer(1, 0);
    chk("t5_ram30", out, 16'h00FE);
    set_mar(16'h0031);
    xfer(1, 0);
    chk("t5_ram31", out, 16'h006B);

`ifdef MEM_PROTECT_EN
    // A protected low byte is dropped and fault stays set until the next request.
    set_mar(16'h000F);
    set_mdr(16'hABCD);
    xfer(0, 1);
    chk("t6_fault", fault, 1);
    set_mar(16'h0010);
    xfer(1, 0);
    chk("t6_ram10", out, 16'h00AB);
    chk("t6_fault_clr", fault, 0);
`endif

    // Random traffic. Requests, loads and sizes are mixed, including cycles where the unit is busy.
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 4) == 0, ($urandom % 4) == 0, $urandom % 2,
           ($urandom % 3) == 0, ($urandom % 3) == 0, 16'($urandom));
    end
    idle_wait();
    step(0, 0, 0, 0, 0, '0);
    checking = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
